// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path.
// Entries carry a destination register and its result.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

endpackage

// File: rtl/wb_entry_fifo.sv
// In-order circular buffer of pending register writes.
// Every slot is exposed so the forward search can scan it.
module wb_entry_fifo
  import regfile_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head_entry,
  output logic [PW-1:0]          head,
  output logic [CW-1:0]          count,
  output logic [DEPTH-1:0]       valid,
  output wb_entry_t [DEPTH-1:0]  slot
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         tail;
  logic [PW-1:0]         age;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_entry;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // A slot is live when its distance from head is below count.
  always_comb begin
    valid = '0;
    age   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      age      = PW'(j) - head;
      valid[j] = ({1'b0, age} < count);
    end
  end

  assign head_entry = mem[head];
  assign slot       = mem;

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write-port owner: arbitrates ALU/load results,
// buffers them in order, drains one per cycle, forwards pending data.
module regfile_writeback_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4:0]        ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              rf_we,
  output logic [4:0]        rf_rd,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic [4:0]        q_rs1,
  input  logic [4:0]        q_rs2,
  output logic              q_rs1_hit,
  output logic              q_rs2_hit,
  output logic [XLEN-1:0]   q_rs1_data,
  output logic [XLEN-1:0]   q_rs2_data,
  output logic              full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  src_e                  rr_last;
  src_e                  grant_src;
  logic                  grant;
  logic                  push;
  logic                  at_cap;
  wb_entry_t             in_entry;
  wb_entry_t             head_entry;
  wb_entry_t [DEPTH-1:0] slot;
  logic [DEPTH-1:0]      valid;
  logic [PW-1:0]         head;
  logic [CW-1:0]         count;
  logic [PW-1:0]         idx;
  logic [REG_AW-1:0]     q_rs   [2];
  logic [1:0]            q_hit;
  logic [XLEN-1:0]       q_data [2];

  assign at_cap = (count == CW'(DEPTH));
  assign full   = !reset && at_cap;

  always_comb begin
    grant     = 1'b0;
    grant_src = SRC_ALU;
    if (!reset && !at_cap) begin
      unique case (1'b1)
        alu_valid && ld_valid: begin
          grant     = 1'b1;
          grant_src = (rr_last == SRC_ALU) ? SRC_LD : SRC_ALU;
        end
        alu_valid && !ld_valid: begin
          grant     = 1'b1;
          grant_src = SRC_ALU;
        end
        !alu_valid && ld_valid: begin
          grant     = 1'b1;
          grant_src = SRC_LD;
        end
        default: ;
      endcase
    end
  end

  assign alu_ready = grant && (grant_src == SRC_ALU);
  assign ld_ready  = grant && (grant_src == SRC_LD);

  assign in_entry = (grant_src == SRC_LD)
                  ? '{rd: ld_rd, data: ld_data}
                  : '{rd: alu_rd, data: alu_data};

  // Writes to x0 complete the handshake but are dropped here.
  assign push = grant && (in_entry.rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= SRC_ALU;
    end else if (grant) begin
      rr_last <= grant_src;
    end
  end

  wb_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (in_entry),
    .pop        (rf_we),
    .head_entry (head_entry),
    .head       (head),
    .count      (count),
    .valid      (valid),
    .slot       (slot)
  );

  assign rf_we    = !reset && (count != '0);
  assign rf_rd    = rf_we ? head_entry.rd   : '0;
  assign rf_wdata = rf_we ? head_entry.data : '0;

  assign q_rs[0] = q_rs1;
  assign q_rs[1] = q_rs2;

  // Scan oldest to youngest so the youngest match is the one kept.
  always_comb begin
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      q_hit[p]  = 1'b0;
      q_data[p] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      for (int p = 0; p < 2; p++) begin
        if (!reset && valid[idx] && q_rs[p] != '0
            && slot[idx].rd == q_rs[p]) begin
          q_hit[p]  = 1'b1;
          q_data[p] = slot[idx].data;
        end
      end
    end
  end

  assign q_rs1_hit  = q_hit[0];
  assign q_rs2_hit  = q_hit[1];
  assign q_rs1_data = q_data[0];
  assign q_rs2_data = q_data[1];

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Scoreboard bench for regfile_writeback_ctrl.
// Reference model is a plain queue of pending writes.
module tb_regfile_writeback_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_rs1_hit;
  logic        q_rs2_hit;
  logic [31:0] q_rs1_data;
  logic [31:0] q_rs2_data;
  logic        full;

  always #5 clk = ~clk;

  regfile_writeback_ctrl #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .q_rs1      (q_rs1),
    .q_rs2      (q_rs2),
    .q_rs1_hit  (q_rs1_hit),
    .q_rs2_hit  (q_rs2_hit),
    .q_rs1_data (q_rs1_data),
    .q_rs2_data (q_rs2_data),
    .full       (full)
  );

  ent_t pend[$];
  ent_t sb[$];
  logic m_rr_ld;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void qmodel(input logic [4:0] rs, output logic h,
                                 output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (rs != 5'd0) begin
      foreach (pend[k]) begin
        if (pend[k].rd == rs) begin
          h = 1'b1;
          d = pend[k].data;
        end
      end
    end
  endfunction

  // Called just after a rising edge; checks the cycle, then advances the model.
  task automatic step();
    logic        ga, gl, exp_we, h;
    logic [31:0] d;
    ent_t        e;
    #3;
    ga = 1'b0;
    gl = 1'b0;
    if (!reset && pend.size() < DEPTH) begin
      if (alu_valid && ld_valid) begin
        if (m_rr_ld) ga = 1'b1;
        else gl = 1'b1;
      end else if (alu_valid) begin
        ga = 1'b1;
      end else if (ld_valid) begin
        gl = 1'b1;
      end
    end
    exp_we = !reset && pend.size() > 0;
    chk("alu_ready", alu_ready, ga);
    chk("ld_ready", ld_ready, gl);
    chk("rf_we", rf_we, exp_we);
    chk("full", full, !reset && pend.size() == DEPTH);
    if (!exp_we) begin
      chk("idle_rd", rf_rd, 0);
      chk("idle_wdata", rf_wdata, 0);
    end
    qmodel(reset ? 5'd0 : q_rs1, h, d);
    chk("q_rs1_hit", q_rs1_hit, h);
    chk("q_rs1_data", q_rs1_data, d);
    qmodel(reset ? 5'd0 : q_rs2, h, d);
    chk("q_rs2_hit", q_rs2_hit, h);
    chk("q_rs2_data", q_rs2_data, d);
    @(posedge clk);
    if (reset) begin
      pend.delete();
      sb.delete();
      m_rr_ld = 1'b0;
    end else begin
      if (pend.size() > 0) void'(pend.pop_front());
      if (ga || gl) begin
        m_rr_ld = gl;
        e.rd    = gl ? ld_rd : alu_rd;
        e.data  = gl ? ld_data : alu_data;
        if (e.rd != 5'd0) begin
          pend.push_back(e);
          sb.push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rf_we === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL stray_write: rd=%0d data=%h, expected none",
                   rf_rd, rf_wdata);
        end else begin
          e = sb.pop_front();
          chk("wr_rd", rf_rd, e.rd);
          chk("wr_data", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin : stim
    reset     = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_rd     = '0;
    ld_data   = '0;
    q_rs1     = '0;
    q_rs2     = '0;
    m_rr_ld   = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;

    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEAD_BEEF;
    q_rs1     = 5'd5;
    step();
    idle();
    step();
    step();

    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1;
      ld_valid  = 1'b1;
      alu_rd    = 5'(10 + i);
      ld_rd     = 5'(20 + i);
      alu_data  = $urandom;
      ld_data   = $urandom;
      q_rs1     = 5'(10 + i);
      q_rs2     = 5'(20 + i);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      alu_rd   = 5'($urandom_range(1, 31));
      ld_rd    = 5'($urandom_range(1, 31));
      alu_data = $urandom;
      ld_data  = $urandom;
      step();
    end
    idle();
    step();

    q_rs1     = 5'd7;
    q_rs2     = 5'd0;
    alu_valid = 1'b1;
    alu_rd    = 5'd7;
    alu_data  = 32'h11;
    step();
    alu_valid = 1'b0;
    ld_valid  = 1'b1;
    ld_rd     = 5'd7;
    ld_data   = 32'h22;
    step();
    idle();
    step();
    step();

    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'hFFFF_FFFF;
    q_rs1     = 5'd0;
    step();
    idle();
    step();

    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 32'h9999_0000;
    q_rs1     = 5'd9;
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();

    for (int i = 0; i < 80; i++) begin
      reset     = ($urandom_range(0, 24) == 0);
      alu_valid = 1'($urandom_range(0, 1));
      ld_valid  = 1'($urandom_range(0, 1));
      alu_rd    = 5'($urandom_range(0, 7));
      ld_rd     = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_data   = $urandom;
      q_rs1     = 5'($urandom_range(0, 7));
      q_rs2     = 5'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    idle();
    step();
    step();
    chk("drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
